// File: rtl/synth_sequencer_if.sv
// Register-port bundle between the event sequencer and its
// table memory / synth_interface targets.
interface synth_sequencer_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ren;
    logic [31:0]       mem_rdata;
    logic              mem_ready;
    logic [3:0]        bus_addr;
    logic [31:0]       bus_data;
    logic              bus_wen;
    logic              bus_ren;
    logic              bus_ready;

    modport master (
        output mem_addr, mem_ren,
        output bus_addr, bus_data,
        output bus_wen, bus_ren,
        input  mem_rdata, mem_ready,
        input  bus_ready
    );

    modport slave (
        input  mem_addr, mem_ren,
        input  bus_addr, bus_data,
        input  bus_wen, bus_ren,
        output mem_rdata, mem_ready,
        output bus_ready
    );
endinterface

// File: rtl/synth_sequencer.sv
// Event-table walker: fetch two-word events, wait tick delay,
// then write one voice register on the synth bus.
module synth_sequencer #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              tick,
    synth_sequencer_if.master sif,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RD0, S_GAP0, S_RD1,
        S_WAIT, S_WR, S_GAP1
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_ptr;
    logic [15:0]       r_delay;
    logic [3:0]        r_voice;
    logic              r_end;
    logic [31:0]       r_val;
    logic [15:0]       r_cnt;
    logic [TW-1:0]     r_to;
    logic              r_stop_pend;
    logic              r_done;
    logic              r_err;
    logic              w_req;
    logic              w_rd;
    logic              w_rdy;
    logic              w_tmo;
    logic              w_done;

    assign w_rd  = (r_state == S_RD0) || (r_state == S_RD1);
    assign w_req = w_rd || (r_state == S_WR);
    assign w_rdy = w_rd ? sif.mem_ready : sif.bus_ready;
    assign w_tmo = w_req && !w_rdy
                && (r_to == TW'(TIMEOUT - 1));

    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        unique case (r_state)
            S_IDLE: if (start && !stop) w_next = S_RD0;
            S_RD0: begin
                if (stop)               w_next = S_IDLE;
                else if (sif.mem_ready) w_next = S_GAP0;
                else if (w_tmo)         w_next = S_IDLE;
            end
            S_GAP0: w_next = stop ? S_IDLE : S_RD1;
            S_RD1: begin
                if (stop)               w_next = S_IDLE;
                else if (sif.mem_ready) w_next = S_WAIT;
                else if (w_tmo)         w_next = S_IDLE;
            end
            S_WAIT: begin
                if (stop)             w_next = S_IDLE;
                else if (r_cnt == '0) w_next = S_WR;
            end
            // An issued write is always carried to completion.
            S_WR: begin
                if (sif.bus_ready)
                    w_next = (r_stop_pend || stop) ? S_IDLE : S_GAP1;
                else if (w_tmo)
                    w_next = S_IDLE;
            end
            S_GAP1: begin
                if (stop || r_end) w_next = S_IDLE;
                else               w_next = S_RD0;
                w_done = r_end && !stop;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_delay     <= '0;
            r_voice     <= '0;
            r_end       <= 1'b0;
            r_val       <= '0;
            r_cnt       <= '0;
            r_to        <= '0;
            r_stop_pend <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_done;
            r_stop_pend <= (r_state == S_WR) && (w_next == S_WR)
                        && (r_stop_pend || stop);
            if (r_state == S_IDLE && w_next == S_RD0) begin
                r_ptr <= base_addr;
                r_err <= 1'b0;
            end
            if (w_tmo) r_err <= 1'b1;
            if (r_state == S_RD0 && w_next == S_GAP0) begin
                r_delay <= sif.mem_rdata[31:16];
                r_voice <= sif.mem_rdata[15:12];
                r_end   <= sif.mem_rdata[0];
                r_ptr   <= r_ptr + 1'b1;
            end
            if (r_state == S_RD1 && w_next == S_WAIT) begin
                r_val <= sif.mem_rdata;
                r_cnt <= r_delay;
                r_ptr <= r_ptr + 1'b1;
            end
            if (r_state == S_WAIT && tick && r_cnt != '0)
                r_cnt <= r_cnt - 1'b1;
            // Restart the ready watchdog on every state change.
            if (r_state != w_next) r_to <= '0;
            else if (w_req)        r_to <= r_to + 1'b1;
        end
    end

    assign sif.mem_ren  = w_rd;
    assign sif.mem_addr = w_rd ? r_ptr : '0;
    assign sif.bus_wen  = (r_state == S_WR);
    assign sif.bus_addr = sif.bus_wen ? r_voice : 4'd0;
    assign sif.bus_data = sif.bus_wen ? r_val : 32'd0;
    assign sif.bus_ren  = 1'b0;
    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign err  = r_err;
endmodule

// File: tb/tb_synth_sequencer.sv
// Directed bench for synth_sequencer with table memory and
// synth bus responders.
module tb_synth_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] base_addr = '0;
    logic        tick = 1'b0;
    logic        busy, done, err;

    int n_chk = 0;
    int n_fail = 0;
    int hold = 2;
    int wcnt = 0;
    int tcnt = 0;
    int dcnt = 0;

    logic [31:0] mem [0:65535];
    logic [3:0]  q_wa [$];
    logic [31:0] q_wd [$];
    int          q_wt [$];
    logic [15:0] q_ra [$];

    synth_sequencer_if #(.ADDR_W(16)) sif ();

    synth_sequencer #(.ADDR_W(16), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .base_addr(base_addr), .tick(tick), .sif(sif),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Ready is registered off req and held while req stays high.
    always @(posedge clk) begin
        sif.mem_ready <= sif.mem_ren;
        sif.mem_rdata <= mem[sif.mem_addr];
        if (sif.bus_wen) begin
            wcnt <= wcnt + 1;
            sif.bus_ready <= (hold != 0) && (wcnt + 2 >= hold);
        end else begin
            wcnt <= 0;
            sif.bus_ready <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (tick) tcnt <= tcnt + 1;
        if (done) dcnt <= dcnt + 1;
        if (rst && sif.mem_ren && sif.mem_ready)
            q_ra.push_back(sif.mem_addr);
        if (rst && sif.bus_wen && sif.bus_ready) begin
            q_wa.push_back(sif.bus_addr);
            q_wd.push_back(sif.bus_data);
            q_wt.push_back(tcnt);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input logic [15:0] b);
        base_addr = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_wen(output int n);
        n = 0;
        while (!sif.bus_wen && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic wait_idle(input bit ticks);
        int i;
        i = 0;
        while (busy && i < 2000) begin
            tick = ticks && (i % 3 == 2);
            @(posedge clk);
            #1;
            tick = 1'b0;
            i++;
        end
        chk("idle_reached", busy, 1'b0);
    endtask

    int n, k, nw, nr, nd, tb0;
    bit stable;
    logic [3:0]  a0;
    logic [31:0] d0;

    initial begin
        mem[16'h10] = 32'h0000_3000;
        mem[16'h11] = 32'h8000_0101;
        mem[16'h12] = 32'h0002_5001;
        mem[16'h13] = 32'h0000_0041;
        mem[16'h20] = 32'h0000_7001;
        mem[16'h21] = 32'hDEAD_BEEF;
        mem[16'h30] = 32'h0000_1001;
        mem[16'h31] = 32'h1111_2222;
        mem[16'h40] = 32'h0005_2001;
        mem[16'h41] = 32'h5555_AAAA;
        mem[16'h48] = 32'h0000_4000;
        mem[16'h49] = 32'h1234_5678;
        mem[16'h4A] = 32'h0000_6001;
        mem[16'h4B] = 32'h6666_6666;
        mem[16'hFFFF] = 32'h0000_9001;
        mem[16'h0000] = 32'hCAFE_0000;

        cyc(3);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_ren", sif.mem_ren, 0);
        chk("rst_maddr", sif.mem_addr, 0);
        chk("rst_wen", sif.bus_wen, 0);
        chk("rst_bdata", {sif.bus_addr, sif.bus_data}, 0);
        rst = 1'b1;
        cyc(2);

        // 1: two events, second delayed by two ticks
        pulse_start(16'h10);
        chk("t1_busy", busy, 1);
        wait_wen(n);
        chk("t1_latency", n, 6);
        k = 0;
        while (q_ra.size() < 4 && k < 100) begin
            cyc(1);
            k++;
        end
        cyc(1);
        tb0 = tcnt;
        chk("t1_w0_mid", q_wa.size(), 1);
        wait_idle(1'b1);
        cyc(1);
        chk("t1_nwr", q_wa.size(), 2);
        chk("t1_w0", {q_wa[0], q_wd[0]}, {4'd3, 32'h8000_0101});
        chk("t1_w1", {q_wa[1], q_wd[1]}, {4'd5, 32'h0000_0041});
        chk("t1_ticks", q_wt[1] - tb0, 2);
        chk("t1_done", dcnt, 1);
        chk("t1_err", err, 0);
        chk("t1_bren", sif.bus_ren, 0);

        // 2: slow bus ready holds the write for four cycles
        hold = 4;
        pulse_start(16'h20);
        wait_wen(n);
        chk("t2_wen", sif.bus_wen, 1);
        a0 = sif.bus_addr;
        d0 = sif.bus_data;
        stable = 1'b1;
        k = 0;
        while (sif.bus_wen && k < 50) begin
            k++;
            if (sif.bus_addr !== a0 || sif.bus_data !== d0)
                stable = 1'b0;
            cyc(1);
        end
        chk("t2_hold", k, 4);
        chk("t2_stable", stable, 1);
        chk("t2_data", {a0, d0}, {4'd7, 32'hDEAD_BEEF});
        wait_idle(1'b0);
        cyc(1);
        chk("t2_done", dcnt, 2);

        // 3: bus never ready -> timeout
        hold = 0;
        nd = dcnt;
        pulse_start(16'h30);
        wait_wen(n);
        chk("t3_wen", sif.bus_wen, 1);
        k = 0;
        while (!err && k < 400) begin
            cyc(1);
            k++;
        end
        chk("t3_tmo_cycle", k, 255);
        chk("t3_busy", busy, 0);
        chk("t3_wen_drop", sif.bus_wen, 0);
        cyc(3);
        chk("t3_nodone", dcnt, nd);
        chk("t3_err_sticky", err, 1);

        // 4a: stop while waiting on a 5-tick delay
        hold = 2;
        nw = q_wa.size();
        pulse_start(16'h40);
        chk("t4_err_clr", err, 0);
        cyc(10);
        chk("t4_in_wait", busy, 1);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        chk("t4_stop_idle", busy, 0);
        for (int i = 0; i < 12; i++) begin
            tick = 1'b1;
            cyc(1);
            tick = 1'b0;
        end
        chk("t4_nowr", q_wa.size(), nw);
        chk("t4_nodone", dcnt, nd);

        // 4b: stop during a write finishes that write only
        hold = 3;
        pulse_start(16'h48);
        wait_wen(n);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        chk("t4b_wen_held", sif.bus_wen, 1);
        wait_idle(1'b0);
        cyc(4);
        chk("t4b_nwr", q_wa.size(), nw + 1);
        chk("t4b_w", {q_wa[nw], q_wd[nw]}, {4'd4, 32'h1234_5678});
        chk("t4b_nodone", dcnt, nd);

        // 5: pointer wraps from top of table to zero
        hold = 2;
        nr = q_ra.size();
        nw = q_wa.size();
        pulse_start(16'hFFFF);
        wait_idle(1'b0);
        cyc(1);
        chk("t5_nrd", q_ra.size(), nr + 2);
        chk("t5_ra0", q_ra[nr], 16'hFFFF);
        chk("t5_ra1", q_ra[nr + 1], 16'h0000);
        chk("t5_w", {q_wa[nw], q_wd[nw]}, {4'd9, 32'hCAFE_0000});

        // 6: reset in the middle of a write
        hold = 0;
        pulse_start(16'h30);
        wait_wen(n);
        chk("t6_wen", sif.bus_wen, 1);
        rst = 1'b0;
        cyc(1);
        chk("t6_wen0", sif.bus_wen, 0);
        chk("t6_busy0", busy, 0);
        chk("t6_out0", {sif.mem_ren, sif.mem_addr, sif.bus_addr,
                        sif.bus_data, done, err}, 0);
        rst = 1'b1;
        hold = 2;
        cyc(2);
        nw = q_wa.size();
        nd = dcnt;
        pulse_start(16'h10);
        chk("t6_restart", busy, 1);
        wait_idle(1'b1);
        cyc(1);
        chk("t6_nwr", q_wa.size(), nw + 2);
        chk("t6_done", dcnt, nd + 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
